// File: rtl/stage_sequencer.sv
// Five-stage instruction sequencer.
// It steps a multicycle datapath through Fetch/Decode/Execute/Memory/WriteBack.
// It supports free-run and single-step operation, memory-write stalls with a
// stall watchdog, a HALT opcode, and counters for retired instructions and
// active cycles.
module stage_sequencer #(
  parameter int STALL_LIMIT = 15,
  parameter int COUNT_W     = 16
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Run,
  input  logic               StepMode,
  input  logic               Step,
  input  logic               Halt_Opcode,
  input  logic               WillWriteTo_Memory_H_RF_L,
  input  logic               MemReady,
  output logic [2:0]         Stage,
  output logic               Running,
  output logic               Halted,
  output logic               Fault,
  output logic               InstrDone,
  output logic [COUNT_W-1:0] InstrCount,
  output logic [COUNT_W-1:0] CycleCount
);

  // The stall counter must be able to hold STALL_LIMIT itself.
  localparam int STALL_W = (STALL_LIMIT < 1) ? 1 : $clog2(STALL_LIMIT + 1);

  localparam logic [2:0] STAGE_NONE  = 3'd0;
  localparam logic [2:0] STAGE_FETCH = 3'd1;
  localparam logic [2:0] STAGE_DEC   = 3'd2;
  localparam logic [2:0] STAGE_EXE   = 3'd3;
  localparam logic [2:0] STAGE_MEM   = 3'd4;
  localparam logic [2:0] STAGE_WB    = 3'd5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [2:0]           stage_d;
  logic [STALL_W-1:0]   stall_cnt_q;
  logic [STALL_W-1:0]   stall_cnt_d;
  logic                 step_q;
  logic                 fault_d;
  logic                 done_d;
  logic [COUNT_W-1:0]   instr_cnt_d;
  logic [COUNT_W-1:0]   cycle_cnt_d;
  logic                 step_edge;
  logic                 mem_stall;

  // A button press counts once, on the cycle the level first rises.
  assign step_edge = Step & ~step_q;

  // Memory stage waits while a RAM write is pending and RAM is not ready.
  assign mem_stall = (Stage == STAGE_MEM) & WillWriteTo_Memory_H_RF_L & ~MemReady;

  // Next-state, stage advance, stall watchdog, retire and counter updates.
  always_comb begin
    state_d     = state_q;
    stage_d     = Stage;
    stall_cnt_d = '0;
    fault_d     = Fault;
    done_d      = 1'b0;
    instr_cnt_d = InstrCount;
    cycle_cnt_d = CycleCount;

    case (state_q)
      IDLE: begin
        stage_d = STAGE_NONE;
        if (StepMode ? step_edge : Run) begin
          state_d = ACTIVE;
          stage_d = STAGE_FETCH;
        end
      end

      ACTIVE: begin
        cycle_cnt_d = CycleCount + COUNT_W'(1);
        case (Stage)
          STAGE_FETCH: stage_d = STAGE_DEC;
          STAGE_DEC: begin
            if (Halt_Opcode) begin
              state_d     = HALTED;
              stage_d     = STAGE_NONE;
              done_d      = 1'b1;
              instr_cnt_d = InstrCount + COUNT_W'(1);
            end else begin
              stage_d = STAGE_EXE;
            end
          end
          STAGE_EXE: stage_d = STAGE_MEM;
          STAGE_MEM: begin
            if (mem_stall) begin
              if (stall_cnt_q == STALL_W'(STALL_LIMIT)) begin
                state_d = HALTED;
                stage_d = STAGE_NONE;
                fault_d = 1'b1;
              end else begin
                stall_cnt_d = stall_cnt_q + STALL_W'(1);
              end
            end else begin
              stage_d = STAGE_WB;
            end
          end
          STAGE_WB: begin
            done_d      = 1'b1;
            instr_cnt_d = InstrCount + COUNT_W'(1);
            if (!StepMode && Run) begin
              stage_d = STAGE_FETCH;
            end else begin
              state_d = IDLE;
              stage_d = STAGE_NONE;
            end
          end
          default: stage_d = STAGE_FETCH;
        endcase
      end

      HALTED: begin
        stage_d = STAGE_NONE;
      end

      default: begin
        state_d = IDLE;
        stage_d = STAGE_NONE;
      end
    endcase
  end

  // State register; all outputs are flops so they change only on the edge.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= IDLE;
      Stage       <= STAGE_NONE;
      Running     <= 1'b0;
      Halted      <= 1'b0;
      Fault       <= 1'b0;
      InstrDone   <= 1'b0;
      InstrCount  <= '0;
      CycleCount  <= '0;
      stall_cnt_q <= '0;
      step_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      Stage       <= stage_d;
      Running     <= (state_d == ACTIVE);
      Halted      <= (state_d == HALTED);
      Fault       <= fault_d;
      InstrDone   <= done_d;
      InstrCount  <= instr_cnt_d;
      CycleCount  <= cycle_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      step_q      <= Step;
    end
  end

endmodule

// File: doc/stage_sequencer.md
STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 Parameter STALL_LIMIT, default 15: maximum consecutive memory-stall cycles before a fault.
REQ-002 Parameter COUNT_W, default 16: width of the instruction and cycle counters.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 Clock  input  1  system clock; all state updates on the rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 Run  input  1  level; 1 = free-run when StepMode=0.
REQ-007 StepMode  input  1  level; 1 = single-instruction stepping.
REQ-008 Step  input  1  level from a button; a rising edge starts one instruction in step mode.
REQ-009 Halt_Opcode  input  1  decoded HALT from the instruction register; valid during Stage 2.
REQ-010 WillWriteTo_Memory_H_RF_L  input  1  current instruction writes RAM (1) or the register file (0).
REQ-011 MemReady  input  1  RAM ready to accept a write.
REQ-012 Stage  output  3  0 = none, 1..5 = Fetch/Decode/Execute/Memory/WriteBack; drives the stage tracker.
REQ-013 Running  output  1  1 while the FSM is in ACTIVE.
REQ-014 Halted  output  1  1 while the FSM is in HALTED.
REQ-015 Fault  output  1  sticky; 1 when the stall limit has been exceeded.
REQ-016 InstrDone  output  1  one-cycle pulse when an instruction retires.
REQ-017 InstrCount  output  COUNT_W  retired-instruction count.
REQ-018 CycleCount  output  COUNT_W  clock cycles spent in ACTIVE.

Function
REQ-019 The FSM SHALL have three states: IDLE (Stage=0), ACTIVE (Stage 1..5) and HALTED (Stage=0).
REQ-020 Step SHALL be registered once; a step edge is Step=1 while the registered copy is 0.
REQ-021 In IDLE with StepMode=0 and Run=1, the next cycle SHALL be ACTIVE with Stage=1.
REQ-022 In IDLE with StepMode=1, a step edge SHALL start Stage=1 on the next cycle; Run is ignored.
REQ-023 In ACTIVE, Stage SHALL advance 1->2->3->4->5 by one per clock, unless stalled or halted.
REQ-024 In Stage 4, with WillWriteTo_Memory_H_RF_L=1 and MemReady=0, Stage SHALL hold at 4 and the internal stall counter SHALL increment.
REQ-025 The stall counter SHALL clear whenever Stage is not held at 4.
REQ-026 If the stall counter reaches STALL_LIMIT while still stalled, the next cycle SHALL enter HALTED with Fault=1, Stage=0 and no retire.
REQ-027 In Stage 2 with Halt_Opcode=1, the next cycle SHALL enter HALTED with Stage=0, InstrDone pulsed and InstrCount incremented.
REQ-028 On leaving Stage 5, InstrDone SHALL pulse for one cycle and InstrCount SHALL increment.
REQ-029 On leaving Stage 5, if StepMode=0 and Run=1, the next Stage SHALL be 1; otherwise the FSM SHALL go to IDLE.
REQ-030 Deasserting Run mid-instruction SHALL NOT abort it; the instruction completes through Stage 5.
REQ-031 HALTED SHALL be exited only by Reset; Run and Step are ignored there.
REQ-032 CycleCount SHALL increment on every clock spent in ACTIVE, including stall cycles.
REQ-033 Both counters SHALL wrap modulo 2^COUNT_W without any flag.
REQ-034 Running, Halted and Stage SHALL be registered outputs that change only on the clock edge.
REQ-035 If HALT and a stall could occur together, HALT takes precedence, since it is evaluated in Stage 2.

Reset
REQ-036 Reset=1 SHALL force the next-edge values Stage=0, IDLE, Running=0, Halted=0, Fault=0, InstrDone=0, InstrCount=0, CycleCount=0, stall counter=0 and registered Step=0.
REQ-037 Reset SHALL override every other input, including mid-instruction, mid-stall and in HALTED.

Verification
REQ-038 Reset, then Run=1 and StepMode=0 for 12 cycles with no stalls -> Stage sequence 1,2,3,4,5,1,2,...; InstrDone pulses at cycles 6 and 11; InstrCount=2.
REQ-039 StepMode=1 with three Step pulses of 3 cycles each -> exactly 3 instructions retire; the FSM returns to IDLE (Stage=0) between them; InstrCount=3.
REQ-040 Memory write with MemReady=0 for 4 cycles in Stage 4 -> Stage holds at 4 for 4 extra cycles and then goes to 5; CycleCount=9 for that instruction; Fault=0.
REQ-041 MemReady held at 0 in Stage 4 -> after 15 stall cycles, HALTED with Fault=1 and Stage=0; a following Run=1 causes no change.
REQ-042 Halt_Opcode=1 in Stage 2 -> next Stage=0, Halted=1, InstrDone pulses once; Reset then returns all outputs to 0.
REQ-043 Reset asserted in Stage 3, and InstrCount preset to 0xFFFF before a retire -> Stage=0 and counters 0 after the reset edge; the retire with the counter at 0xFFFF wraps it to 0x0000.
